// File: rtl/decode_pkg.sv
// Shared constants and types for the instruction-decode stage.
package decode_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b000010;

  localparam logic [2:0] DEC_NOP  = 3'b000;
  localparam logic [2:0] DEC_ADD  = 3'b001;
  localparam logic [2:0] DEC_ADDI = 3'b010;
  localparam logic [2:0] DEC_SUB  = 3'b011;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_IMM_W  = 16;

  // Decoded record at default widths; the top mirrors this field order at its own widths.
  typedef struct packed {
    logic [2:0]            opcode;
    logic [DEF_REG_AW-1:0] rs;
    logic [DEF_REG_AW-1:0] rt;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_IMM_W-1:0]  immediate;
    logic                  illegal;
  } dec_rec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/decode_skid.sv
// Generic 2-entry valid/ready skid buffer; output data comes straight from a register.
module decode_skid
  import decode_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_t  r_state;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;
  logic         w_accept;
  logic         w_handshake;

  // Ready looks only at registered occupancy and reset, never at i_ready.
  assign o_ready     = (r_state != ST_FULL) && !rst;
  assign w_accept    = i_valid && o_ready;
  assign w_handshake = r_out_valid && i_ready;
  assign o_valid     = r_out_valid;
  assign o_data      = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= {W{1'b0}};
      r_skid_data <= {W{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_data  <= i_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_handshake) begin
            r_out_data <= i_data;
          end else if (w_accept) begin
            r_skid_data <= i_data;
            r_state     <= ST_FULL;
          end else if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_handshake) begin
            r_out_data  <= r_skid_data;
            r_skid_data <= {W{1'b0}};
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: combinational field decode into a skid buffer,
// with saturating counters of decoded and illegal instructions handed downstream.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         opcode,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [REG_AW-1:0]  rd,
  output logic [IMM_W-1:0]   immediate,
  output logic               illegal,
  output logic [CNT_W-1:0]   decoded_cnt,
  output logic [CNT_W-1:0]   illegal_cnt
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [IMM_W-1:0]  immediate;
    logic              illegal;
  } rec_t;

  localparam int              REC_W   = $bits(rec_t);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [5:0]        w_primary;
  logic [REG_AW-1:0] w_rs_f;
  logic [REG_AW-1:0] w_rt_f;
  logic [REG_AW-1:0] w_rd_f;
  logic [IMM_W-1:0]  w_imm_f;
  rec_t              w_dec;
  rec_t              w_out;
  logic [REC_W-1:0]  w_out_bits;
  logic              w_handshake;
  logic [CNT_W-1:0]  r_decoded_cnt;
  logic [CNT_W-1:0]  r_illegal_cnt;

  assign w_primary = instruction[INSTR_W-1 -: 6];
  assign w_rs_f    = instruction[INSTR_W-7 -: REG_AW];
  assign w_rt_f    = instruction[INSTR_W-7-REG_AW -: REG_AW];
  assign w_rd_f    = instruction[IMM_W-1 -: REG_AW];
  assign w_imm_f   = instruction[IMM_W-1:0];

  // Fields an operation does not use stay zero so nothing leaks from earlier instructions.
  always_comb begin
    w_dec.opcode    = DEC_NOP;
    w_dec.rs        = {REG_AW{1'b0}};
    w_dec.rt        = {REG_AW{1'b0}};
    w_dec.rd        = {REG_AW{1'b0}};
    w_dec.immediate = {IMM_W{1'b0}};
    w_dec.illegal   = 1'b0;
    case (w_primary)
      OP_ADD: begin
        w_dec.opcode = DEC_ADD;
        w_dec.rs     = w_rs_f;
        w_dec.rt     = w_rt_f;
        w_dec.rd     = w_rd_f;
      end
      OP_ADDI: begin
        w_dec.opcode    = DEC_ADDI;
        w_dec.rs        = w_rs_f;
        w_dec.rt        = w_rt_f;
        w_dec.immediate = w_imm_f;
      end
      OP_SUB: begin
        w_dec.opcode = DEC_SUB;
        w_dec.rs     = w_rs_f;
        w_dec.rt     = w_rt_f;
        w_dec.rd     = w_rd_f;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  decode_skid #(
    .W(REC_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_valid(in_valid),
    .o_ready(in_ready),
    .i_data (w_dec),
    .o_valid(out_valid),
    .i_ready(out_ready),
    .o_data (w_out_bits)
  );

  assign w_out       = rec_t'(w_out_bits);
  assign opcode      = w_out.opcode;
  assign rs          = w_out.rs;
  assign rt          = w_out.rt;
  assign rd          = w_out.rd;
  assign immediate   = w_out.immediate;
  assign illegal     = w_out.illegal;
  assign w_handshake = out_valid && out_ready;
  assign decoded_cnt = r_decoded_cnt;
  assign illegal_cnt = r_illegal_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_decoded_cnt <= {CNT_W{1'b0}};
      r_illegal_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_handshake && (r_decoded_cnt != CNT_MAX)) begin
        r_decoded_cnt <= r_decoded_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_handshake && w_out.illegal && (r_illegal_cnt != CNT_MAX)) begin
        r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, back-pressure, reset in FULL, counter saturation.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instruction;
  logic [2:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [15:0] decoded_cnt, illegal_cnt;

  logic        d2_rst, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_illegal;
  logic [31:0] d2_instruction;
  logic [2:0]  d2_opcode;
  logic [4:0]  d2_rs, d2_rt, d2_rd;
  logic [15:0] d2_immediate;
  logic [3:0]  d2_decoded_cnt, d2_illegal_cnt;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
    .illegal(illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(d2_rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .instruction(d2_instruction), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .opcode(d2_opcode), .rs(d2_rs), .rt(d2_rt), .rd(d2_rd), .immediate(d2_immediate),
    .illegal(d2_illegal), .decoded_cnt(d2_decoded_cnt), .illegal_cnt(d2_illegal_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [33:0] pack_out(input logic [2:0] o, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] c,
                                           input logic [15:0] im);
    return {o, a, b, c, im};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] got[$];
    logic [33:0] exp_bp[3];
    int          exp_ill;
    int          d2_stall;
    logic        acc;

    vecs[0] = '{32'h00221800, 3'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b0};
    vecs[1] = '{32'h2022FFFF, 3'd2, 5'd1,  5'd2,  5'd0,  16'hFFFF, 1'b0};
    vecs[2] = '{32'h08221800, 3'd3, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b0};
    vecs[3] = '{32'hFC000000, 3'd0, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b1};
    vecs[4] = '{32'h03E0FFFF, 3'd1, 5'd31, 5'd0,  5'd31, 16'h0000, 1'b0};
    vecs[5] = '{32'h23FFABCD, 3'd2, 5'd31, 5'd31, 5'd0,  16'hABCD, 1'b0};
    vecs[6] = '{32'h04221800, 3'd0, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b1};
    vecs[7] = '{32'h0BFF0000, 3'd3, 5'd31, 5'd31, 5'd0,  16'h0000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instruction = 32'h0;
    d2_rst = 1'b1; d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_instruction = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", pack_out(opcode, rs, rt, rd, immediate), 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_decoded_cnt", decoded_cnt, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);

    rst = 1'b0; d2_rst = 1'b0;
    @(negedge clk);
    chk("first_in_ready", in_ready, 1);

    // Decode table, one instruction at a time with out_ready high
    exp_ill = 0;
    for (int i = 0; i < 8; i++) begin
      instruction = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_fields", i), pack_out(opcode, rs, rt, rd, immediate),
          pack_out(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm));
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
      @(negedge clk);
      exp_ill += int'(vecs[i].ill);
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      chk($sformatf("v%0d_decoded_cnt", i), decoded_cnt, i + 1);
      chk($sformatf("v%0d_illegal_cnt", i), illegal_cnt, exp_ill);
    end

    // Back-pressure: three offered, two accepted, output holds the first
    exp_bp[0] = pack_out(3'd1, 5'd1, 5'd2, 5'd3, 16'h0000);
    exp_bp[1] = pack_out(3'd2, 5'd1, 5'd2, 5'd0, 16'hFFFF);
    exp_bp[2] = pack_out(3'd3, 5'd5, 5'd4, 5'd2, 16'h0000);
    out_ready = 1'b0;
    instruction = 32'h00221800; in_valid = 1'b1;
    chk("bp_ready_a", in_ready, 1);
    @(negedge clk);
    instruction = 32'h2022FFFF;
    chk("bp_ready_b", in_ready, 1);
    @(negedge clk);
    instruction = 32'h08A41000;
    chk("bp_ready_c", in_ready, 0);
    chk("bp_hold1", pack_out(opcode, rs, rt, rd, immediate), exp_bp[0]);
    @(negedge clk);
    chk("bp_ready_c2", in_ready, 0);
    chk("bp_hold2_valid", out_valid, 1);
    chk("bp_hold2", pack_out(opcode, rs, rt, rd, immediate), exp_bp[0]);

    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) got.push_back(pack_out(opcode, rs, rt, rd, immediate));
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 34'h3_FFFF_FFFF, exp_bp[i]);
    end
    chk("bp_decoded_cnt", decoded_cnt, 11);
    chk("bp_illegal_cnt", illegal_cnt, 2);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    instruction = 32'h00221800; in_valid = 1'b1;
    @(negedge clk);
    instruction = 32'hFC000000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("frst_out_valid", out_valid, 0);
    chk("frst_decoded_cnt", decoded_cnt, 0);
    chk("frst_illegal_cnt", illegal_cnt, 0);
    chk("frst_in_ready", in_ready, 0);
    chk("frst_fields", pack_out(opcode, rs, rt, rd, immediate), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("frst_in_ready2", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("frst_release_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), out_valid, 0);
    end
    instruction = 32'h08221800; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_fields", pack_out(opcode, rs, rt, rd, immediate),
        pack_out(3'd3, 5'd1, 5'd2, 5'd3, 16'h0000));
    @(negedge clk);
    chk("post_rst_decoded_cnt", decoded_cnt, 1);
    chk("post_rst_illegal_cnt", illegal_cnt, 0);

    // Saturation with a 4-bit counter and a full-rate stream of 20 illegals
    d2_out_ready = 1'b1;
    d2_stall = 0;
    for (int i = 0; i < 20; i++) begin
      d2_instruction = 32'hFC000000; d2_in_valid = 1'b1;
      if (!d2_in_ready) d2_stall++;
      @(negedge clk);
    end
    d2_in_valid = 1'b0;
    chk("sat_stalls", d2_stall, 0);
    repeat (3) @(negedge clk);
    chk("sat_decoded_cnt", d2_decoded_cnt, 15);
    chk("sat_illegal_cnt", d2_illegal_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage with valid/ready flow control on both sides. It sits between fetch and execute and splits each instruction into an internal opcode, register specifiers and an immediate. A 2-entry skid buffer sustains one instruction per cycle under back-pressure. Illegal primary opcodes are flagged, and decoded and illegal instructions are counted.

## Interface
- `INSTR_W`, default 32: instruction width. Must equal `6 + 2*REG_AW + IMM_W`.
- `REG_AW`, default 5: register specifier width.
- `IMM_W`, default 16: immediate width. Must be at least `REG_AW`.
- `CNT_W`, default 16: statistics counter width.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: upstream instruction present.
- `in_ready`, output, 1: stage can accept.
- `instruction`, input, `INSTR_W`: raw instruction.
- `out_valid`, output, 1: decoded entry present.
- `out_ready`, input, 1: downstream accepts.
- `opcode`, output, 3: internal operation code.
- `rs`, `rt`, `rd`, output, `REG_AW` each: source, target and destination register specifiers.
- `immediate`, output, `IMM_W`: raw immediate, not sign-extended.
- `illegal`, output, 1: primary opcode is not recognised.
- `decoded_cnt`, output, `CNT_W`: count of instructions handed downstream.
- `illegal_cnt`, output, `CNT_W`: count of illegal instructions handed downstream.

## Operation
- Field extraction:
  - primary = `instruction[INSTR_W-1 -: 6]`.
  - rs = next `REG_AW` bits; rt = next `REG_AW` bits.
  - rd = `instruction[IMM_W-1 -: REG_AW]`.
  - immediate = `instruction[IMM_W-1:0]`.
- Decode map:
  - `000000` ADD: opcode `001`; rs, rt, rd valid; immediate = 0.
  - `001000` ADDI: opcode `010`; rs, rt, immediate valid; rd = 0.
  - `000010` SUB: opcode `011`; rs, rt, rd valid; immediate = 0.
  - Any other value: opcode `000`, illegal = 1, all register and immediate fields 0.
- Unused fields are driven 0, never held from a previous instruction.
- Decode is combinational at the input. The decoded record is captured in the output register or the skid register.
- States, by occupancy:
  - EMPTY: output invalid.
  - ONE: output register valid, skid empty.
  - FULL: both registers valid.
- Input accept = `in_valid & in_ready`. Output handshake = `out_valid & out_ready`.
- EMPTY: accept → ONE.
- ONE:
  - accept without handshake → FULL (new record to skid).
  - accept with handshake → ONE (new record to output register).
  - handshake only → EMPTY.
- FULL: handshake → ONE (skid moves to output register). No accept is possible.
- `in_ready` = not FULL and not `rst`.
- Output fields are held stable while `out_valid & !out_ready`.
- Order is strictly preserved.
- Counters:
  - On each output handshake, `decoded_cnt` increments by 1.
  - If that handshake has `illegal` = 1, `illegal_cnt` also increments by 1.
  - Both saturate at all-ones and do not wrap.
- Reset:
  - State EMPTY; `out_valid`, `opcode`, `rs`, `rt`, `rd`, `immediate`, `illegal` = 0.
  - Both counters = 0; `in_ready` = 0 while `rst` is high.
  - Reset mid-operation discards buffered entries without a handshake and without counting them.

## Timing
- Latency from accept to `out_valid` is 1 cycle when the stage is EMPTY, or ONE with a simultaneous handshake.
- Throughput is 1 instruction per cycle with `out_ready` held high.
- `in_ready` depends only on registered state and `rst`. There is no combinational path from `out_ready`.
- Counters update on the clock edge after the handshake cycle.
- First accept is possible in the cycle after `rst` deasserts.

## Structure
- Package `decode_pkg` holds:
  - primary-opcode constants (`OP_ADD`, `OP_ADDI`, `OP_SUB`);
  - internal code constants (`DEC_NOP`, `DEC_ADD`, `DEC_ADDI`, `DEC_SUB`);
  - the decoded-record struct (opcode, rs, rt, rd, immediate, illegal).
- Sub-module `decode_skid` is a generic 2-entry valid/ready skid buffer over the packed record.
- The top level contains the decode logic, the `decode_skid` instance and the counters.

## Test plan
- ADD `0x00221800`, `out_ready` = 1 → next cycle: opcode `001`, rs = 1, rt = 2, rd = 3, immediate = 0, illegal = 0; `decoded_cnt` = 1.
- ADDI `0x2022FFFF` → opcode `010`, rs = 1, rt = 2, rd = 0, immediate = `0xFFFF`. SUB `0x08221800` → opcode `011`, rs = 1, rt = 2, rd = 3.
- Illegal `0xFC000000` → opcode `000`, illegal = 1, all fields 0; `illegal_cnt` = 1, `decoded_cnt` = 1.
- Back-pressure:
  - Stimulus: `out_ready` = 0, three back-to-back instructions offered.
  - Required: two accepted, then `in_ready` = 0. Output is held on the first instruction.
  - Then raise `out_ready`: all three emerge in order with no loss or duplication.
- Reset in FULL state → next cycle `out_valid` = 0, counters = 0, `in_ready` = 0 until `rst` falls. No stale entry appears afterwards.
- With `CNT_W` = 4 and 20 illegal instructions streamed → both counters stick at 15.
